// File: rtl/i2c_master.sv
// Register-access I2C master: single-byte register write, or register read via repeated start.
// Open-drain bus through scl_oe/sda_oe; SCL runs at f_clk/(4*QDIV), no clock stretching.
module i2c_master #(
  parameter int unsigned QDIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] slv_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_data
);
  // state  | meaning
  // IDLE   | bus released, waiting for start
  // START  | SDA falls with SCL high, then SCL falls
  // ADDR   | shift {slv_addr, r/w} MSB first
  // ACK    | master releases SDA, slave ACK sampled at q2
  // REG    | shift reg_addr
  // WDATA  | shift wr_data
  // RSTART | repeated start before the read address
  // RDATA  | master releases SDA, 8 bits shifted in
  // MACK   | master NACK (SDA released) after the read byte
  // STOP   | SDA rises while SCL high
  // DONE   | one-cycle done pulse
  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK, REG, WDATA, RSTART, RDATA, MACK, STOP, DONE
  } state_t;

  localparam logic [7:0] TICK_RELOAD = 8'(QDIV - 1);

  state_t     state_q, state_d, ack_from_q;
  logic [7:0] tick_cnt_q;
  logic [1:0] qtr_q;
  logic [2:0] bit_q;
  logic [7:0] sh_q;
  logic [6:0] slv_q;
  logic [7:0] reg_q, wd_q;
  logic       rw_q, nack_q, rd_phase_q;
  logic       tick, bit_end, byte_end, scl_low, shifting;

  assign tick     = busy && (tick_cnt_q == 8'd0);
  assign bit_end  = tick && (qtr_q == 2'd3);
  assign byte_end = bit_end && (bit_q == 3'd7);
  assign scl_low  = (qtr_q == 2'd0) || (qtr_q == 2'd3);
  assign shifting = (state_q == ADDR) || (state_q == REG) || (state_q == WDATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    scl_oe  = 1'b0;
    sda_oe  = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = START;
      end
      START: begin
        sda_oe = (qtr_q != 2'd0);
        scl_oe = (qtr_q == 2'd3);
        if (bit_end) state_d = ADDR;
      end
      ADDR, REG, WDATA: begin
        scl_oe = scl_low;
        sda_oe = ~sh_q[7];
        if (byte_end) state_d = ACK;
      end
      ACK: begin
        scl_oe = scl_low;
        if (bit_end) begin
          if (nack_q) state_d = STOP;
          else begin
            case (ack_from_q)
              ADDR:    state_d = rd_phase_q ? RDATA : REG;
              REG:     state_d = rw_q ? RSTART : WDATA;
              default: state_d = STOP;
            endcase
          end
        end
      end
      RSTART: begin
        // SDA released through q1, pulled low in q2 while SCL is high
        scl_oe = scl_low;
        sda_oe = qtr_q[1];
        if (bit_end) state_d = ADDR;
      end
      RDATA: begin
        scl_oe = scl_low;
        if (byte_end) state_d = MACK;
      end
      MACK: begin
        scl_oe = scl_low;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        scl_oe = (qtr_q == 2'd0);
        sda_oe = (qtr_q == 2'd0) || (qtr_q == 2'd1);
        if (bit_end) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= 8'd0;
      qtr_q      <= 2'd0;
      bit_q      <= 3'd0;
      sh_q       <= 8'd0;
      slv_q      <= 7'd0;
      reg_q      <= 8'd0;
      wd_q       <= 8'd0;
      rw_q       <= 1'b0;
      nack_q     <= 1'b0;
      rd_phase_q <= 1'b0;
      ack_from_q <= IDLE;
      ack_err    <= 1'b0;
      rd_data    <= 8'd0;
    end else begin
      if (!busy)     tick_cnt_q <= TICK_RELOAD;
      else if (tick) tick_cnt_q <= TICK_RELOAD;
      else           tick_cnt_q <= tick_cnt_q - 8'd1;
      if (tick) qtr_q <= qtr_q + 2'd1;

      if (bit_end && (shifting || state_q == RDATA)) bit_q <= bit_q + 3'd1;

      if (state_q == IDLE && start) begin
        rw_q       <= rw;
        slv_q      <= slv_addr;
        reg_q      <= reg_addr;
        wd_q       <= wr_data;
        nack_q     <= 1'b0;
        rd_phase_q <= 1'b0;
        ack_err    <= 1'b0;
      end

      if (state_q == ACK && tick && qtr_q == 2'd2 && sda_in) nack_q <= 1'b1;
      if (state_q == RSTART && bit_end) rd_phase_q <= 1'b1;
      if (state_d == ACK && state_q != ACK) ack_from_q <= state_q;

      if (state_q == RDATA && tick && qtr_q == 2'd2) sh_q <= {sh_q[6:0], sda_in};
      if (bit_end && shifting) sh_q <= {sh_q[6:0], 1'b0};
      // byte loads take priority over the shift on the entering bit_end
      if (bit_end && state_d != state_q) begin
        case (state_d)
          ADDR:    sh_q <= {slv_q, state_q == RSTART};
          REG:     sh_q <= reg_q;
          WDATA:   sh_q <= wd_q;
          default: ;
        endcase
      end

      // results become visible together with the done pulse
      if (state_q == STOP && bit_end) begin
        ack_err <= nack_q;
        if (rw_q && !nack_q) rd_data <= sh_q;
      end
    end
  end
endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: behavioural slave + bus decoder on a QDIV=4 instance,
// and an SCL phase / SDA-while-SCL-high monitor on an unacknowledged QDIV=2 instance.
module tb_i2c_master;
  localparam int TOK_S  = 256;
  localparam int TOK_SR = 257;
  localparam int TOK_P  = 258;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] slv_addr = 7'd0;
  logic [7:0] reg_addr = 8'd0;
  logic [7:0] wr_data = 8'd0;
  logic       sda_in, scl_oe, sda_oe, busy, done, ack_err;
  logic [7:0] rd_data;

  logic       start2 = 1'b0;
  logic       sda_in2, scl_oe2, sda_oe2, busy2, done2, ack_err2;
  logic [7:0] rd_data2;

  int checks = 0;
  int failures = 0;

  // slave / decoder state, owned by the monitor process
  logic       pull = 1'b0;
  logic       ack_en = 1'b1;
  logic [7:0] rd_byte = 8'hA7;
  int         tok_q[$];
  logic       ack_q[$];
  int         done_cnt = 0;
  int         clr_req = 0;
  int         clr_seen = 0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1, mon_scl, mon_sda;
  logic       in_frame = 1'b0, rd_mode = 1'b0, first_byte = 1'b0;
  int         bitn = 0;
  logic [7:0] sh = 8'd0;

  int         exp_tok[$];
  logic       exp_ack[$];

  // QDIV=2 phase monitor state
  logic p2_scl = 1'b1, p2_sda = 1'b1, m2_scl, m2_sda, seen_fall = 1'b0;
  int   run_len = 0, min_len = 1000, max_len = 0, n_int = 0, hi_chg = 0;

  assign sda_in  = ~(sda_oe | pull);
  assign sda_in2 = ~sda_oe2;

  always #5 clk = ~clk;

  i2c_master #(.QDIV(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .slv_addr(slv_addr),
    .reg_addr(reg_addr), .wr_data(wr_data), .sda_in(sda_in), .scl_oe(scl_oe),
    .sda_oe(sda_oe), .busy(busy), .done(done), .ack_err(ack_err), .rd_data(rd_data)
  );

  i2c_master #(.QDIV(2)) u_dut_q2 (
    .clk(clk), .rst(rst), .start(start2), .rw(1'b0), .slv_addr(7'h5A),
    .reg_addr(8'h02), .wr_data(8'h3C), .sda_in(sda_in2), .scl_oe(scl_oe2),
    .sda_oe(sda_oe2), .busy(busy2), .done(done2), .ack_err(ack_err2), .rd_data(rd_data2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int near(input int got, input int exp);
    return (got >= exp - 2 && got <= exp + 2) ? exp : got;
  endfunction

  task automatic do_start(input logic r, input logic [6:0] sa, input logic [7:0] ra,
                          input logic [7:0] wd);
    @(negedge clk);
    rw = r; slv_addr = sa; reg_addr = ra; wr_data = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 3000) check_val({tag, "_timeout"}, done, 1);
  endtask

  task automatic clr_log;
    clr_req++;
    @(negedge clk);
    #1;
  endtask

  task automatic cmp_log(input string tag);
    check_val({tag, "_ntok"}, tok_q.size(), exp_tok.size());
    for (int i = 0; i < exp_tok.size(); i++)
      if (i < tok_q.size()) check_val($sformatf("%s_tok%0d", tag, i), tok_q[i], exp_tok[i]);
    check_val({tag, "_nack"}, ack_q.size(), exp_ack.size());
    for (int i = 0; i < exp_ack.size(); i++)
      if (i < ack_q.size()) check_val($sformatf("%s_ack%0d", tag, i), ack_q[i], exp_ack[i]);
  endtask

  // slave + bus decoder: S/Sr/P tokens and bytes in tok_q, ACK-slot levels in ack_q
  initial forever begin
    @(negedge clk);
    mon_scl = ~scl_oe;
    mon_sda = ~(sda_oe | pull);
    if (done) done_cnt++;
    if (clr_req != clr_seen) begin
      tok_q.delete(); ack_q.delete();
      in_frame = 1'b0; rd_mode = 1'b0; first_byte = 1'b0; bitn = 0; pull = 1'b0;
      clr_seen = clr_req;
    end else if (prev_scl && mon_scl && prev_sda && !mon_sda) begin
      tok_q.push_back(in_frame ? TOK_SR : TOK_S);
      in_frame = 1'b1; bitn = 0; first_byte = 1'b1; rd_mode = 1'b0; pull = 1'b0;
    end else if (prev_scl && mon_scl && !prev_sda && mon_sda) begin
      tok_q.push_back(TOK_P);
      in_frame = 1'b0; bitn = 0; rd_mode = 1'b0; pull = 1'b0;
    end else if (!prev_scl && mon_scl) begin
      if (bitn < 8) begin
        sh = {sh[6:0], mon_sda};
        bitn++;
        if (bitn == 8) tok_q.push_back(int'(sh));
      end else if (bitn == 8) begin
        ack_q.push_back(mon_sda);
        if (first_byte && sh[0] && !mon_sda) rd_mode = 1'b1;
        else if (rd_mode && mon_sda) rd_mode = 1'b0;
        first_byte = 1'b0;
        bitn = 9;
      end
    end else if (prev_scl && !mon_scl) begin
      if (bitn == 9) begin
        bitn = 0;
        pull = rd_mode & ~rd_byte[7];
      end else if (bitn == 8) pull = rd_mode ? 1'b0 : ack_en;
      else if (rd_mode && bitn > 0) pull = ~rd_byte[3'(7 - bitn)];
      else pull = 1'b0;
    end
    prev_scl = mon_scl;
    prev_sda = ~(sda_oe | pull);
  end

  // QDIV=2 instance: SCL phase lengths after the first fall, SDA edges while SCL high
  initial forever begin
    @(negedge clk);
    m2_scl = ~scl_oe2;
    m2_sda = ~sda_oe2;
    run_len++;
    if (m2_scl != p2_scl) begin
      if (seen_fall) begin
        if (run_len < min_len) min_len = run_len;
        if (run_len > max_len) max_len = run_len;
        n_int++;
      end
      if (!m2_scl) seen_fall = 1'b1;
      run_len = 0;
    end
    if (p2_scl && m2_scl && m2_sda != p2_sda) hi_chg++;
    p2_scl = m2_scl;
    p2_sda = m2_sda;
  end

  initial begin
    int cyc;
    int d0;
    repeat (3) @(negedge clk);
    check_val("rst_scl_oe", scl_oe, 0);
    check_val("rst_sda_oe", sda_oe, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_ack_err", ack_err, 0);
    check_val("rst_rd_data", rd_data, 8'h00);
    rst = 1'b0;
    clr_log();

    // QDIV=2, nobody answers: START, 0xB4, NACK, STOP
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    cyc = 0;
    while (done2 !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check_val("q2_done", done2, 1);
    check_val("q2_cycles", near(cyc, 88), 88);
    check_val("q2_busy_at_done", busy2, 0);
    check_val("q2_ack_err", ack_err2, 1);
    check_val("q2_rd_data", rd_data2, 8'h00);
    repeat (4) @(negedge clk);
    check_val("q2_scl_phase_min", min_len, 4);
    check_val("q2_scl_phase_max", max_len, 4);
    check_val("q2_scl_phases", n_int, 19);
    check_val("q2_sda_hi_changes", hi_chg, 2);

    // register write
    clr_log();
    do_start(1'b0, 7'h5A, 8'h02, 8'h3C);
    check_val("wr_busy", busy, 1);
    wait_done("wr", cyc);
    check_val("wr_cycles", near(cyc, 464), 464);
    check_val("wr_busy_at_done", busy, 0);
    check_val("wr_ack_err", ack_err, 0);
    exp_tok = '{TOK_S, 'hB4, 'h02, 'h3C, TOK_P};
    exp_ack = '{1'b0, 1'b0, 1'b0};
    cmp_log("wr");

    // register read with repeated start
    clr_log();
    do_start(1'b1, 7'h5A, 8'h05, 8'h00);
    wait_done("rd", cyc);
    check_val("rd_cycles", near(cyc, 624), 624);
    check_val("rd_data", rd_data, 8'hA7);
    check_val("rd_ack_err", ack_err, 0);
    exp_tok = '{TOK_S, 'hB4, 'h05, TOK_SR, 'hB5, 'hA7, TOK_P};
    exp_ack = '{1'b0, 1'b0, 1'b0, 1'b1};
    cmp_log("rd");

    // address NACK
    ack_en = 1'b0;
    clr_log();
    d0 = done_cnt;
    do_start(1'b0, 7'h5A, 8'h02, 8'h3C);
    wait_done("nack", cyc);
    check_val("nack_cycles", near(cyc, 176), 176);
    check_val("nack_ack_err", ack_err, 1);
    repeat (10) @(negedge clk);
    check_val("nack_ack_err_held", ack_err, 1);
    check_val("nack_done_count", done_cnt - d0, 1);
    check_val("nack_rd_data_held", rd_data, 8'hA7);
    exp_tok = '{TOK_S, 'hB4, TOK_P};
    exp_ack = '{1'b1};
    cmp_log("nack");
    ack_en = 1'b1;

    // start while busy is ignored
    clr_log();
    d0 = done_cnt;
    do_start(1'b0, 7'h5A, 8'h02, 8'h3C);
    check_val("ign_ack_err_cleared", ack_err, 0);
    repeat (100) @(negedge clk);
    do_start(1'b1, 7'h11, 8'hFF, 8'h00);
    wait_done("ign", cyc);
    repeat (20) @(negedge clk);
    check_val("ign_done_count", done_cnt - d0, 1);
    check_val("ign_busy_after", busy, 0);
    check_val("ign_ack_err", ack_err, 0);
    exp_tok = '{TOK_S, 'hB4, 'h02, 'h3C, TOK_P};
    exp_ack = '{1'b0, 1'b0, 1'b0};
    cmp_log("ign");

    // reset in q0 of REG bit 3, then a fresh write
    clr_log();
    do_start(1'b0, 7'h5A, 8'h02, 8'h3C);
    repeat (209) @(negedge clk);
    check_val("mid_busy_before", busy, 1);
    check_val("mid_scl_oe_before", scl_oe, 1);
    check_val("mid_sda_oe_before", sda_oe, 1);
    #1 rst = 1'b1;
    #1;
    check_val("mid_rst_scl_oe", scl_oe, 0);
    check_val("mid_rst_sda_oe", sda_oe, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_done", done, 0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    clr_log();
    do_start(1'b0, 7'h5A, 8'h10, 8'hC3);
    wait_done("post", cyc);
    check_val("post_cycles", near(cyc, 464), 464);
    check_val("post_ack_err", ack_err, 0);
    exp_tok = '{TOK_S, 'hB4, 'h10, 'hC3, TOK_P};
    exp_ack = '{1'b0, 1'b0, 1'b0};
    cmp_log("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter QDIV, default 4: clk cycles per quarter SCL period; legal range 2..255; SCL frequency = f_clk/(4*QDIV).
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request; sampled only in IDLE.
REQ-005 rw  input  1  transaction type: 0 = register write, 1 = register read; sampled with start.
REQ-006 slv_addr  input  7  target 7-bit address, e.g. {3'b101, sel[3:0]}; sampled with start.
REQ-007 reg_addr  input  8  target register address; sampled with start.
REQ-008 wr_data  input  8  write payload; sampled with start.
REQ-009 sda_in  input  1  bus SDA level; sampled at the SCL-high midpoint.
REQ-010 scl_oe  output  1  1 = drive SCL low, 0 = release (open-drain).
REQ-011 sda_oe  output  1  1 = drive SDA low, 0 = release (open-drain).
REQ-012 busy  output  1  high from accepted start until done.
REQ-013 done  output  1  one-cycle pulse at transaction end.
REQ-014 ack_err  output  1  set at done when any ACK slot saw SDA high; held until the next accepted start.
REQ-015 rd_data  output  8  byte read, MSB first; valid at done of a read; held until the next read.

Function
REQ-016 A quarter-tick counter shall run only while busy; it shall emit one tick every QDIV clks; all bus phase changes occur on ticks.
REQ-017 States: IDLE, START, ADDR, ACK, REG, WDATA, RSTART, RDATA, MACK, STOP, DONE.
REQ-018 IDLE: scl_oe=0 and sda_oe=0; start=1 latches inputs, sets busy next cycle and enters START.
REQ-019 START: SDA falls while SCL is released, then SCL falls; one bit period (4 ticks).
REQ-020 Each bit shall take 4 ticks: q0 SCL low with SDA set; q1 SCL released; q2 SCL high with sda_in sampled; q3 SCL low.
REQ-021 ADDR shall shift {slv_addr,0} MSB first, then ACK; REG shall send reg_addr, then ACK.
REQ-022 Write: WDATA shall send wr_data, then ACK, then STOP.
REQ-023 Read: after the REG ACK, RSTART shall release SDA with SCL high, then pull SDA low; the controller shall then send {slv_addr,1}, take ACK, run RDATA (8 bits, master releases SDA), and drive MACK as NACK (SDA released), then STOP.
REQ-024 ACK slot: the master releases SDA; sda_in=1 at q2 sets the error flag, and the next state shall be STOP with all remaining bytes skipped.
REQ-025 STOP: SDA low, SCL released, then SDA released; then DONE.
REQ-026 DONE: for one cycle, done=1, busy=0, and ack_err is updated; then IDLE. Back-to-back start is accepted on the cycle after done.
REQ-027 start while busy shall be ignored, with no change to latched inputs.
REQ-028 The bit counter shall be 3 bits and wrap 7->0 at byte end; the tick counter shall be 8 bits.
REQ-029 No clock stretching; SCL level is not monitored.
REQ-030 Total SCL bit periods: write 29 including START/STOP; read 39 including the repeated START.

Reset
REQ-031 rst=1 shall immediately force IDLE, scl_oe=0, sda_oe=0, busy=0, done=0, ack_err=0, rd_data=8'h00, and clear all counters.
REQ-032 rst asserted mid-transfer shall release both lines the same cycle with no STOP generated; operation resumes only via a new start after rst falls.

Verification
REQ-033 QDIV=4, write: slv_addr=7'h5A, reg_addr=8'h02, wr_data=8'h3C, slave ACKs -> bus shows START, 0xB4, 0x02, 0x3C, STOP; done after 29*16 clks ±2; ack_err=0.
REQ-034 Read: slv_addr=7'h5A, reg_addr=8'h05, slave returns 8'hA7 -> bus shows 0xB4, 0x05, Sr, 0xB5, 0xA7 with master NACK, STOP; rd_data=8'hA7; ack_err=0.
REQ-035 Address NACK (no slave ACK) -> STOP immediately after the first ACK slot; done pulses; ack_err=1; no REG byte on the bus.
REQ-036 start pulsed again 100 clks into a transfer with different inputs -> bus bytes unchanged; exactly one done.
REQ-037 rst pulsed during REG bit 3 -> scl_oe=0 and sda_oe=0 in the same cycle; busy=0; a new write afterwards completes correctly.
REQ-038 SCL timing check with QDIV=2 -> high and low phases are each 4 clks, and SDA changes only while SCL is low except at START/Sr/STOP.
